life_rule_engine: RTL and testbench
===================================

Name: life_rule_engine

Overview:
- Parametrised successor to the fixed 16x16 B3/S23 life core.
- Holds an X-by-Y cell grid and computes generations one cell per clock.
- Rule set is programmable (Life-like birth/survive masks); edge mode is selectable as torus or dead border.
- Provides cursor editing from pulsed keys, a generation counter, and a row-scanned display output for the LED matrix driver.

Parameters:
- X, 16, grid width (columns)
- Y, 16, grid height (rows)
- LOG2X, 4, cursor/column index width; 2**LOG2X >= X
- LOG2Y, 4, row index width; 2**LOG2Y >= Y
- HIGH_BITS, 32, generation counter width
- WRAP, 1, 1 = toroidal neighbours, 0 = out-of-grid neighbours read as dead
- BIRTH, 9'b000001000, bit n set => dead cell with n neighbours is born
- SURVIVE, 9'b000001100, bit n set => live cell with n neighbours survives

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- key_nxt  in  1  one-cycle pulse: start one generation
- key_flip  in  1  one-cycle pulse: invert cell under cursor
- key_up / key_down / key_left / key_right  in  1 each  one-cycle cursor moves
- row  out  Y  one-hot active row select
- col  out  X  cell data of active row, bit x = cell (x,row)
- busy  out  1  high while a generation is in progress
- done  out  1  one-cycle pulse when a generation commits
- gen_count  out  HIGH_BITS  generations completed since reset

Behaviour:
- Grid storage: cur and nxt, each X*Y bits; cell (x,y) is bit y*X+x.
- Reset (async, low):
  - cur, nxt = 0; cursor = (0,0); state IDLE; gen_count = 0
  - busy = 0; done = 0; scan index = 0; row = 1; col = 0
  - Reset during COMPUTE aborts the generation; the grid is cleared.
- FSM states: IDLE, COMPUTE, COMMIT.
  - IDLE: key_nxt -> COMPUTE, cell index i = 0, busy = 1 from the next cycle.
  - COMPUTE: each clock, count the 8 neighbours of cell i in cur (0..8, 4 bits); write nxt[i] = cur[i] ? SURVIVE[n] : BIRTH[n]; i++. When i == X*Y-1 -> COMMIT.
  - COMMIT: cur <= nxt; gen_count++ (wraps modulo 2**HIGH_BITS); done = 1 for the following cycle only; -> IDLE; busy = 0.
  - Latency from key_nxt to cur updated: X*Y+1 clocks. Minimum key_nxt spacing: X*Y+2.
- Neighbour coordinates:
  - WRAP=1: x-1 at x=0 is X-1; x+1 at X-1 is 0; same rule for y.
  - WRAP=0: any out-of-range neighbour counts as 0.
- Keys while busy (COMPUTE/COMMIT): all ignored, including key_nxt; no queuing.
- Editing (IDLE only):
  - key_flip inverts cur at the cursor.
  - left/right move x by -1/+1, up/down move y by -1/+1; all moves wrap modulo X or Y, regardless of WRAP.
  - left+right in the same cycle: no x move. up+down in the same cycle: no y move.
  - A flip and a move in the same cycle: the flip applies at the old cursor position.
  - key_nxt with key_flip in the same cycle: the flip commits at that edge; COMPUTE reads the flipped grid.
- Display:
  - Scan index advances 0..Y-1 every clock and wraps.
  - row and col are registered: row = one-hot(scan); col = cur[scan*X +: X].
  - During COMPUTE, col shows cur (the old generation), never nxt.

Optional Feature:
- Macro: LIFE_CURSOR_BLINK_EN.
- Defined:
  - A 20-bit free-running blink counter (reset 0) is added.
  - When the counter MSB is 1 and the state is IDLE, the col bit at the cursor is inverted on the scan row equal to cursor y.
  - The stored cur is unaffected.
- Undefined: no counter; col is exactly the stored row data.

Decomposition:
- Shared package life_pkg:
  - state enum (IDLE/COMPUTE/COMMIT)
  - default rule constants LIFE_B3S23_BIRTH and LIFE_B3S23_SURVIVE
  - HighLife constants B36_BIRTH=9'b001001000, S23
  - index helper function cell_idx(x,y,X)
- Sub-module life_nbr_count: 8 one-bit inputs -> 4-bit population count. Purely combinational; instantiated once.

Test Plan:
- Blinker: X=Y=16, WRAP=1. Flip (7,8),(8,8),(9,8); key_nxt -> after X*Y+1 clocks cur has (8,7),(8,8),(8,9) live; done pulses once; gen_count=1; second key_nxt restores the horizontal blinker; gen_count=2.
- Edge mode: single glider run 4*N generations across the right edge. WRAP=1 -> reappears at x=0 with an intact 5-cell shape. WRAP=0 -> becomes a 2x2 block at the edge, population 4, stable.
- Custom rule BIRTH=9'b000000010, SURVIVE=0: single live cell (8,8), one step -> its 8 neighbours live, centre dead, population 8.
- Cursor: from reset, key_left -> cursor x=15; key_up -> y=15; flip -> cur bit 255 = 1; left+right in the same cycle -> cursor unchanged.
- Busy: key_nxt, then key_nxt and key_flip at clock +10 -> single generation only, gen_count=1, no flip, busy high exactly X*Y+1 cycles.
- Reset: assert reset at clock +100 of COMPUTE -> next edge shows busy=0, gen_count=0, grid all 0, row=1, col=0; no done pulse.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the life rule engine: FSM state encoding, rule masks
// and the flat cell index helper.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } life_state_t;

    // Rule masks: bit n set means the rule fires with n live neighbours.
    localparam logic [8:0] LIFE_B3S23_BIRTH   = 9'b000001000;
    localparam logic [8:0] LIFE_B3S23_SURVIVE = 9'b000001100;
    localparam logic [8:0] LIFE_B36_BIRTH     = 9'b001001000;
    localparam logic [8:0] LIFE_S23_SURVIVE   = 9'b000001100;

    function automatic int cell_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/life_nbr_count.sv
// Population count of the eight neighbour bits of one cell (result 0..8).
module life_nbr_count (
    input  logic [7:0] nb,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int k = 0; k < 8; k++) begin
            count = count + {3'b000, nb[k]};
        end
    end

endmodule

// File: rtl/life_rule_engine.sv
// Programmable Life-like cellular automaton, one cell evaluated per clock,
// with cursor editing and row-scanned display. Optional: LIFE_CURSOR_BLINK_EN.
module life_rule_engine
    import life_pkg::*;
#(
    parameter int         X         = 16,
    parameter int         Y         = 16,
    parameter int         LOG2X     = 4,
    parameter int         LOG2Y     = 4,
    parameter int         HIGH_BITS = 32,
    parameter int         WRAP      = 1,
    parameter logic [8:0] BIRTH     = LIFE_B3S23_BIRTH,
    parameter logic [8:0] SURVIVE   = LIFE_B3S23_SURVIVE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_nxt,
    input  logic                 key_flip,
    input  logic                 key_up,
    input  logic                 key_down,
    input  logic                 key_left,
    input  logic                 key_right,
    output logic [Y-1:0]         row,
    output logic [X-1:0]         col,
    output logic                 busy,
    output logic                 done,
    output logic [HIGH_BITS-1:0] gen_count,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] COMMIT  = ST_COMMIT;

    localparam logic [LOG2X-1:0] X_LAST = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] Y_LAST = LOG2Y'(Y - 1);

    // Keys are single-cycle pulses sampled on the rising clock edge. They are
    // accepted only in IDLE; while busy they are dropped (no queuing, no ready).
    logic [1:0]                 state;
    logic [Y-1:0][X-1:0]        cur;
    logic [Y-1:0][X-1:0]        nxt;
    logic [LOG2X-1:0]           cur_x, cur_x_nxt;
    logic [LOG2Y-1:0]           cur_y, cur_y_nxt;
    logic [LOG2X-1:0]           cx;
    logic [LOG2Y-1:0]           cy;
    logic [LOG2Y-1:0]           scan;
    logic [Y-1:0]               row_next;
    logic [X-1:0]               col_next;

    logic [LOG2X-1:0] xm, xp;
    logic [LOG2Y-1:0] ym, yp;
    logic             xm_ok, xp_ok, ym_ok, yp_ok;
    logic [7:0]       nb;
    logic [3:0]       n_live;
    logic             next_cell;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign xm = (cx == '0)     ? X_LAST : cx - LOG2X'(1);
    assign xp = (cx == X_LAST) ? '0     : cx + LOG2X'(1);
    assign ym = (cy == '0)     ? Y_LAST : cy - LOG2Y'(1);
    assign yp = (cy == Y_LAST) ? '0     : cy + LOG2Y'(1);

    // In dead-border mode the wrapped coordinate is still computed but masked.
    assign xm_ok = (WRAP != 0) || (cx != '0);
    assign xp_ok = (WRAP != 0) || (cx != X_LAST);
    assign ym_ok = (WRAP != 0) || (cy != '0);
    assign yp_ok = (WRAP != 0) || (cy != Y_LAST);

    assign nb = {ym_ok & xm_ok & cur[ym][xm],
                 ym_ok &         cur[ym][cx],
                 ym_ok & xp_ok & cur[ym][xp],
                 xm_ok &         cur[cy][xm],
                 xp_ok &         cur[cy][xp],
                 yp_ok & xm_ok & cur[yp][xm],
                 yp_ok &         cur[yp][cx],
                 yp_ok & xp_ok & cur[yp][xp]};

    life_nbr_count u_nbr_count (
        .nb    (nb),
        .count (n_live)
    );

    assign next_cell = cur[cy][cx] ? SURVIVE[n_live] : BIRTH[n_live];

    // Opposite keys on the same axis cancel; cursor always wraps.
    always_comb begin
        cur_x_nxt = cur_x;
        cur_y_nxt = cur_y;
        if (key_left && !key_right) begin
            cur_x_nxt = (cur_x == '0) ? X_LAST : cur_x - LOG2X'(1);
        end else if (key_right && !key_left) begin
            cur_x_nxt = (cur_x == X_LAST) ? '0 : cur_x + LOG2X'(1);
        end
        if (key_up && !key_down) begin
            cur_y_nxt = (cur_y == '0) ? Y_LAST : cur_y - LOG2Y'(1);
        end else if (key_down && !key_up) begin
            cur_y_nxt = (cur_y == Y_LAST) ? '0 : cur_y + LOG2Y'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= '0;
            nxt       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            cx        <= '0;
            cy        <= '0;
            gen_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_flip) begin
                        cur[cur_y][cur_x] <= ~cur[cur_y][cur_x];
                    end
                    cur_x <= cur_x_nxt;
                    cur_y <= cur_y_nxt;
                    if (key_nxt) begin
                        state <= COMPUTE;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                COMPUTE: begin
                    nxt[cy][cx] <= next_cell;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            state <= COMMIT;
                        end else begin
                            cy <= cy + LOG2Y'(1);
                        end
                    end else begin
                        cx <= cx + LOG2X'(1);
                    end
                end
                COMMIT: begin
                    cur       <= nxt;
                    gen_count <= gen_count + 1'b1;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        row_next       = '0;
        row_next[scan] = 1'b1;
    end

`ifdef LIFE_CURSOR_BLINK_EN
    logic [19:0]  blink_cnt;
    logic [X-1:0] blink_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 20'd1;
        end
    end

    // The blink only alters what is displayed; cur itself is untouched.
    always_comb begin
        blink_mask = '0;
        if (blink_cnt[19] && (state == IDLE) && (scan == cur_y)) begin
            blink_mask[cur_x] = 1'b1;
        end
    end

    assign col_next = cur[scan] ^ blink_mask;
`else
    assign col_next = cur[scan];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan <= '0;
            row  <= Y'(1);
            col  <= '0;
        end else begin
            scan <= (scan == Y_LAST) ? '0 : scan + LOG2Y'(1);
            row  <= row_next;
            col  <= col_next;
        end
    end

endmodule

// File: tb/tb_life_rule_engine.sv
// Randomised bench for life_rule_engine: three instances (torus, dead border,
// custom B1/S) share one key stream and are compared to a cell-level model.
`timescale 1ns/1ps
module tb_life_rule_engine;
    import life_pkg::*;

    localparam int X  = 16;
    localparam int Y  = 16;
    localparam int N  = X * Y;
    localparam int HB = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_nxt = 1'b0, key_flip = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;

    logic [Y-1:0]  row_v  [NI];
    logic [X-1:0]  col_v  [NI];
    logic          busy_v [NI];
    logic          done_v [NI];
    logic [HB-1:0] gen_v  [NI];
    logic [1:0]    dbg_v  [NI];

    always #5 clk = ~clk;

    life_rule_engine #(.WRAP(1)) u_torus (
        .clk(clk), .reset(reset), .key_nxt(key_nxt), .key_flip(key_flip),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .row(row_v[0]), .col(col_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .gen_count(gen_v[0]), .dbg_state(dbg_v[0]));

    life_rule_engine #(.WRAP(0)) u_border (
        .clk(clk), .reset(reset), .key_nxt(key_nxt), .key_flip(key_flip),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .row(row_v[1]), .col(col_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .gen_count(gen_v[1]), .dbg_state(dbg_v[1]));

    life_rule_engine #(.WRAP(1), .BIRTH(9'b000000010), .SURVIVE(9'b000000000)) u_custom (
        .clk(clk), .reset(reset), .key_nxt(key_nxt), .key_flip(key_flip),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .row(row_v[2]), .col(col_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .gen_count(gen_v[2]), .dbg_state(dbg_v[2]));

    // Reference model state
    int         m_wrap  [NI] = '{1, 0, 1};
    logic [8:0] m_birth [NI] = '{LIFE_B3S23_BIRTH, LIFE_B3S23_BIRTH, 9'b000000010};
    logic [8:0] m_surv  [NI] = '{LIFE_B3S23_SURVIVE, LIFE_B3S23_SURVIVE, 9'b000000000};
    logic [N-1:0] m_grid [NI];
    int           m_cx, m_cy;
    logic [HB-1:0] m_gen;

    logic [X-1:0] exp_q [$];
    int n_vec = 0;
    int n_bad = 0;
    int pop_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_step(input logic [N-1:0] g, input int wrap,
                                              input logic [8:0] b, input logic [8:0] s);
        logic [N-1:0] r;
        int n, nx, ny;
        r = '0;
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        nx = x + dx;
                        ny = y + dy;
                        if (wrap != 0) begin
                            nx = (nx + X) % X;
                            ny = (ny + Y) % Y;
                        end else if (nx < 0 || nx >= X || ny < 0 || ny >= Y) begin
                            continue;
                        end
                        n += int'(g[cell_idx(nx, ny, X)]);
                    end
                end
                r[cell_idx(x, y, X)] = g[cell_idx(x, y, X)] ? s[n] : b[n];
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NI; k++) m_grid[k] = '0;
        m_cx  = 0;
        m_cy  = 0;
        m_gen = '0;
    endtask

    // Drive one cycle of keys from a negedge and mirror the edit in the model.
    task automatic press(input bit l, input bit r, input bit u, input bit d,
                         input bit f, input bit nx);
        key_left = l; key_right = r; key_up = u; key_down = d;
        key_flip = f; key_nxt = nx;
        @(negedge clk);
        key_left = 0; key_right = 0; key_up = 0; key_down = 0;
        key_flip = 0; key_nxt = 0;
        if (f) begin
            for (int k = 0; k < NI; k++)
                m_grid[k][cell_idx(m_cx, m_cy, X)] = ~m_grid[k][cell_idx(m_cx, m_cy, X)];
        end
        if (l && !r) m_cx = (m_cx + X - 1) % X;
        else if (r && !l) m_cx = (m_cx + 1) % X;
        if (u && !d) m_cy = (m_cy + Y - 1) % Y;
        else if (d && !u) m_cy = (m_cy + 1) % Y;
    endtask

    task automatic move_to(input int tx, input int ty);
        for (int i = 0; i < X && m_cx != tx; i++) press(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < Y && m_cy != ty; i++) press(0, 0, 0, 1, 0, 0);
    endtask

    task automatic flip_at(input int tx, input int ty);
        move_to(tx, ty);
        press(0, 0, 0, 0, 1, 0);
    endtask

    // One generation; optionally inject nxt+flip while busy (must be ignored).
    task automatic run_gen(input bit with_flip, input int inject);
        int bc, dc;
        bc = 0;
        dc = 0;
        press(0, 0, 0, 0, with_flip, 1);
        for (int k = 0; k < NI; k++)
            m_grid[k] = ref_step(m_grid[k], m_wrap[k], m_birth[k], m_surv[k]);
        m_gen = m_gen + 1'b1;
        for (int c = 0; c < N + 8; c++) begin
            if (busy_v[0]) bc++;
            if (done_v[0]) dc++;
            if (c == inject) begin
                key_nxt = 1; key_flip = 1;
            end else begin
                key_nxt = 0; key_flip = 0;
            end
            @(negedge clk);
        end
        check("busy_cycles", bc, N + 1);
        check("done_pulses", dc, 1);
        for (int k = 0; k < NI; k++) check("gen_count", gen_v[k], m_gen);
    endtask

    // Capture all rows through the scanned display and compare to the model.
    task automatic read_check(input string tag, output int pop_custom);
        logic [X-1:0] got [NI][Y];
        for (int k = 0; k < NI; k++)
            for (int r = 0; r < Y; r++) exp_q.push_back(m_grid[k][r*X +: X]);
        for (int c = 0; c < Y; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                for (int r = 0; r < Y; r++)
                    if (row_v[k][r]) got[k][r] = col_v[k];
        end
        check({tag, "_onehot"}, 64'($onehot(row_v[0])), 1);
        pop_custom = 0;
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < Y; r++) begin
                check($sformatf("%s_i%0d_r%0d", tag, k, r), got[k][r], exp_q.pop_front());
                if (k == 2) pop_custom += $countones(got[k][r]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_busy"}, busy_v[k], 0);
            check({tag, "_done"}, done_v[k], 0);
            check({tag, "_gen"}, gen_v[k], 0);
            check({tag, "_row"}, row_v[k], 1);
            check({tag, "_col"}, col_v[k], 0);
            check({tag, "_state"}, dbg_v[k], ST_IDLE);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        model_clear();
    endtask

    initial begin
        int dc;
        model_clear();
        #1 reset = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1;
        read_check("empty", pop_c);

        // Cursor wrap and opposite-key cancellation
        press(1, 0, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        read_check("cursor_255", pop_c);
        press(1, 1, 1, 1, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        read_check("cursor_cancel", pop_c);

        // Blinker, two generations
        flip_at(7, 8);
        flip_at(8, 8);
        flip_at(9, 8);
        read_check("blinker_g0", pop_c);
        run_gen(0, -1);
        read_check("blinker_g1", pop_c);
        run_gen(0, -1);
        read_check("blinker_g2", pop_c);

        // Keys during busy are ignored
        run_gen(0, 10);
        read_check("busy_ignore", pop_c);

        // Reset in the middle of COMPUTE
        press(0, 0, 0, 0, 1, 1);
        repeat (99) @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1;
        model_clear();
        dc = 0;
        for (int c = 0; c < N + 8; c++) begin
            @(negedge clk);
            if (done_v[0]) dc++;
        end
        check("mid_reset_no_done", dc, 0);
        read_check("mid_reset_grid", pop_c);

        // Single cell under B1/S (custom instance): ring of 8
        flip_at(8, 8);
        run_gen(0, -1);
        read_check("custom", pop_c);
        check("custom_pop", pop_c, 8);

        // Random edits followed by a generation
        for (int round = 0; round < 4; round++) begin
            pulse_reset();
            for (int i = 0; i < 150; i++)
                press($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1), 0);
            read_check($sformatf("rand%0d_edit", round), pop_c);
            run_gen($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 250) : -1);
            read_check($sformatf("rand%0d_gen", round), pop_c);
        end

        // Glider heading into the right/bottom edge
        pulse_reset();
        flip_at(11, 5);
        flip_at(12, 6);
        flip_at(10, 7);
        flip_at(11, 7);
        flip_at(12, 7);
        for (int g = 0; g < 36; g++) begin
            run_gen(0, -1);
            if (g % 4 == 3) read_check($sformatf("glider_g%0d", g + 1), pop_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
